// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Completion-side broadcaster for the Common Data Bus. Each functional unit
// drops finished results into its own small FIFO. Every cycle one FIFO head
// is picked round-robin and its result is registered onto the CDB, where the
// ROB, the reservation stations and the map table pick it up.
//
// Ports
//   clock            sole clock, rising edge
//   reset            synchronous, active-high; clears FIFOs, rr pointer, CDB
//   squash_signal    synchronous flush, asserted with the ROB flush
//   fu_valid[i]      FU i offers a result this cycle
//   fu_ready[i]      FIFO i is not full (registered occupancy only)
//   fu_tag           NUM_FU x TAG_W  ROB tag per FU
//   fu_value         NUM_FU x XLEN   destination value per FU
//   fu_alu_result    NUM_FU x XLEN   branch target / raw ALU output per FU
//   fu_pc, fu_npc, fu_inst  NUM_FU x XLEN  PC, next PC, encoding per FU
//   fu_take_branch   NUM_FU          resolved branch flag per FU
//   cdb_*            registered broadcast packet
//   cdb_grant_fu     source FU of the current broadcast
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int BUF_DEPTH = 2,
    parameter int XLEN      = 32,
    parameter int ROB_SIZE  = 32,
    localparam int TAG_W    = $clog2(ROB_SIZE),
    localparam int GNT_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash_signal,

    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*XLEN-1:0]   fu_value,
    input  logic [NUM_FU*XLEN-1:0]   fu_alu_result,
    input  logic [NUM_FU*XLEN-1:0]   fu_pc,
    input  logic [NUM_FU*XLEN-1:0]   fu_npc,
    input  logic [NUM_FU*XLEN-1:0]   fu_inst,
    input  logic [NUM_FU-1:0]        fu_take_branch,

    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [XLEN-1:0]          cdb_value,
    output logic [XLEN-1:0]          cdb_alu_result,
    output logic [XLEN-1:0]          cdb_pc,
    output logic [XLEN-1:0]          cdb_npc,
    output logic [XLEN-1:0]          cdb_inst,
    output logic                     cdb_take_branch,
    output logic [GNT_W-1:0]         cdb_grant_fu
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    // FIFO pointers carry one extra wrap bit so full and empty are distinct.
    logic [PTR_W:0]     head [NUM_FU];
    logic [PTR_W:0]     tail [NUM_FU];

    // Per-FU result storage.
    logic [TAG_W-1:0]   tag_mem    [NUM_FU][BUF_DEPTH];
    logic [XLEN-1:0]    value_mem  [NUM_FU][BUF_DEPTH];
    logic [XLEN-1:0]    alu_mem    [NUM_FU][BUF_DEPTH];
    logic [XLEN-1:0]    pc_mem     [NUM_FU][BUF_DEPTH];
    logic [XLEN-1:0]    npc_mem    [NUM_FU][BUF_DEPTH];
    logic [XLEN-1:0]    inst_mem   [NUM_FU][BUF_DEPTH];
    logic               br_mem     [NUM_FU][BUF_DEPTH];

    logic [NUM_FU-1:0]  full;
    logic [NUM_FU-1:0]  empty;
    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  pop;

    logic [GNT_W-1:0]   rr_ptr;
    logic [GNT_W-1:0]   winner;
    logic               winner_found;
    logic [GNT_W:0]     search_sum;
    logic [GNT_W-1:0]   search_idx;
    logic [PTR_W-1:0]   win_head;

    // Occupancy flags. Full means same slot index with opposite wrap bits.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            full[i]  = (head[i][PTR_W-1:0] == tail[i][PTR_W-1:0]) &&
                       (head[i][PTR_W] != tail[i][PTR_W]);
            empty[i] = (head[i] == tail[i]);
        end
    end

    // Ready looks only at stored occupancy: a full FIFO that pops this cycle
    // still refuses, which keeps fu_ready free of any path from arbitration.
    assign fu_ready = ~full;

    // A squash drops whatever the FUs offer in the same cycle.
    always_comb begin
        push = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            push[i] = fu_valid[i] && !full[i] && !squash_signal;
        end
    end

    // Round-robin search over FIFO heads, starting at rr_ptr and wrapping
    // modulo NUM_FU. The first non-empty FIFO wins. Incoming results are not
    // candidates, so every result spends at least one cycle in its FIFO.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        search_sum   = '0;
        search_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            search_sum = {1'b0, rr_ptr} + (GNT_W+1)'(k);
            if (search_sum >= (GNT_W+1)'(NUM_FU)) begin
                search_sum = search_sum - (GNT_W+1)'(NUM_FU);
            end
            search_idx = search_sum[GNT_W-1:0];
            if (!winner_found && !empty[search_idx]) begin
                winner       = search_idx;
                winner_found = 1'b1;
            end
        end
    end

    // The winner is popped unless a squash is flushing everything anyway.
    always_comb begin
        pop = '0;
        if (winner_found && !squash_signal) begin
            pop[winner] = 1'b1;
        end
    end

    assign win_head = head[winner][PTR_W-1:0];

    // Pointer update. Reset and squash both empty every FIFO on this edge.
    always_ff @(posedge clock) begin
        if (reset || squash_signal) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    tail[i] <= tail[i] + (PTR_W+1)'(1);
                end
                if (pop[i]) begin
                    head[i] <= head[i] + (PTR_W+1)'(1);
                end
            end
        end
    end

    // Storage write. Slots need no reset; the pointers define what is live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                tag_mem[i][tail[i][PTR_W-1:0]]   <= fu_tag[i*TAG_W +: TAG_W];
                value_mem[i][tail[i][PTR_W-1:0]] <= fu_value[i*XLEN +: XLEN];
                alu_mem[i][tail[i][PTR_W-1:0]]   <= fu_alu_result[i*XLEN +: XLEN];
                pc_mem[i][tail[i][PTR_W-1:0]]    <= fu_pc[i*XLEN +: XLEN];
                npc_mem[i][tail[i][PTR_W-1:0]]   <= fu_npc[i*XLEN +: XLEN];
                inst_mem[i][tail[i][PTR_W-1:0]]  <= fu_inst[i*XLEN +: XLEN];
                br_mem[i][tail[i][PTR_W-1:0]]    <= fu_take_branch[i];
            end
        end
    end

    // Broadcast register and rr pointer. With no winner, or on a squash, only
    // cdb_valid drops; the data fields keep their last values. A broadcast
    // already on the bus when squash arrives is left alone -- the ROB discards
    // it through its own flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr          <= '0;
            cdb_valid       <= 1'b0;
            cdb_tag         <= '0;
            cdb_value       <= '0;
            cdb_alu_result  <= '0;
            cdb_pc          <= '0;
            cdb_npc         <= '0;
            cdb_inst        <= '0;
            cdb_take_branch <= 1'b0;
            cdb_grant_fu    <= '0;
        end else if (squash_signal) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
        end else if (winner_found) begin
            rr_ptr          <= (winner == GNT_W'(NUM_FU-1)) ? '0 : winner + GNT_W'(1);
            cdb_valid       <= 1'b1;
            cdb_tag         <= tag_mem[winner][win_head];
            cdb_value       <= value_mem[winner][win_head];
            cdb_alu_result  <= alu_mem[winner][win_head];
            cdb_pc          <= pc_mem[winner][win_head];
            cdb_npc         <= npc_mem[winner][win_head];
            cdb_inst        <= inst_mem[winner][win_head];
            cdb_take_branch <= br_mem[winner][win_head];
            cdb_grant_fu    <= winner;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter. A queue-per-FU reference model tracks
// what each FIFO should hold, which FU should win each cycle and what the CDB
// should show; directed scenarios are followed by a randomized run with
// occasional squash and reset.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NUM_FU    = 4;
    localparam int BUF_DEPTH = 2;
    localparam int XLEN      = 32;
    localparam int ROB_SIZE  = 32;
    localparam int TAG_W     = $clog2(ROB_SIZE);
    localparam int GNT_W     = $clog2(NUM_FU);

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     squash_signal;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU-1:0]        fu_ready;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*XLEN-1:0]   fu_value;
    logic [NUM_FU*XLEN-1:0]   fu_alu_result;
    logic [NUM_FU*XLEN-1:0]   fu_pc;
    logic [NUM_FU*XLEN-1:0]   fu_npc;
    logic [NUM_FU*XLEN-1:0]   fu_inst;
    logic [NUM_FU-1:0]        fu_take_branch;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [XLEN-1:0]          cdb_value;
    logic [XLEN-1:0]          cdb_alu_result;
    logic [XLEN-1:0]          cdb_pc;
    logic [XLEN-1:0]          cdb_npc;
    logic [XLEN-1:0]          cdb_inst;
    logic                     cdb_take_branch;
    logic [GNT_W-1:0]         cdb_grant_fu;

    cdb_arbiter #(
        .NUM_FU    (NUM_FU),
        .BUF_DEPTH (BUF_DEPTH),
        .XLEN      (XLEN),
        .ROB_SIZE  (ROB_SIZE)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .squash_signal   (squash_signal),
        .fu_valid        (fu_valid),
        .fu_ready        (fu_ready),
        .fu_tag          (fu_tag),
        .fu_value        (fu_value),
        .fu_alu_result   (fu_alu_result),
        .fu_pc           (fu_pc),
        .fu_npc          (fu_npc),
        .fu_inst         (fu_inst),
        .fu_take_branch  (fu_take_branch),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_value       (cdb_value),
        .cdb_alu_result  (cdb_alu_result),
        .cdb_pc          (cdb_pc),
        .cdb_npc         (cdb_npc),
        .cdb_inst        (cdb_inst),
        .cdb_take_branch (cdb_take_branch),
        .cdb_grant_fu    (cdb_grant_fu)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  npc;
        logic [XLEN-1:0]  inst;
        logic             take_branch;
    } entry_t;

    // Reference model state.
    entry_t model_q [NUM_FU][$];
    int     model_rr;
    entry_t exp_pkt;
    logic   exp_valid;
    int     exp_grant;

    int tests_run;
    int tests_failed;

    // One comparison: counted, and reported on mismatch.
    task automatic compare(input string name, input logic [XLEN-1:0] observed,
                           input logic [XLEN-1:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // Drive control inputs and fresh random payloads for every FU.
    task automatic applyStimulus(input logic rst, input logic sq, input logic [NUM_FU-1:0] vld);
        reset         = rst;
        squash_signal = sq;
        fu_valid      = vld;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i*TAG_W +: TAG_W]       = TAG_W'($urandom);
            fu_value[i*XLEN +: XLEN]       = $urandom;
            fu_alu_result[i*XLEN +: XLEN]  = $urandom;
            fu_pc[i*XLEN +: XLEN]          = $urandom;
            fu_npc[i*XLEN +: XLEN]         = $urandom;
            fu_inst[i*XLEN +: XLEN]        = $urandom;
            fu_take_branch[i]              = 1'($urandom);
        end
    endtask

    // Override the recognizable fields of one FU for directed cases.
    task automatic setFu(input int i, input logic [TAG_W-1:0] tag,
                         input logic [XLEN-1:0] value, input logic [XLEN-1:0] pc);
        fu_tag[i*TAG_W +: TAG_W] = tag;
        fu_value[i*XLEN +: XLEN] = value;
        fu_pc[i*XLEN +: XLEN]    = pc;
    endtask

    function automatic entry_t inputEntry(input int i);
        entry_t e;
        e.tag         = fu_tag[i*TAG_W +: TAG_W];
        e.value       = fu_value[i*XLEN +: XLEN];
        e.alu_result  = fu_alu_result[i*XLEN +: XLEN];
        e.pc          = fu_pc[i*XLEN +: XLEN];
        e.npc         = fu_npc[i*XLEN +: XLEN];
        e.inst        = fu_inst[i*XLEN +: XLEN];
        e.take_branch = fu_take_branch[i];
        return e;
    endfunction

    function automatic logic [NUM_FU-1:0] expReady();
        logic [NUM_FU-1:0] r;
        for (int i = 0; i < NUM_FU; i++) begin
            r[i] = (model_q[i].size() < BUF_DEPTH);
        end
        return r;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NUM_FU; i++) begin
            model_q[i].delete();
        end
        model_rr  = 0;
        exp_valid = 1'b0;
        exp_pkt   = '0;
        exp_grant = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic modelEdge();
        bit accept [NUM_FU];
        int win;
        if (reset) begin
            modelReset();
        end else if (squash_signal) begin
            for (int i = 0; i < NUM_FU; i++) begin
                model_q[i].delete();
            end
            model_rr  = 0;
            exp_valid = 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                accept[i] = fu_valid[i] && (model_q[i].size() < BUF_DEPTH);
            end
            win = -1;
            for (int k = 0; k < NUM_FU; k++) begin
                if (win < 0 && model_q[(model_rr + k) % NUM_FU].size() > 0) begin
                    win = (model_rr + k) % NUM_FU;
                end
            end
            if (win >= 0) begin
                exp_pkt   = model_q[win].pop_front();
                exp_valid = 1'b1;
                exp_grant = win;
                model_rr  = (win + 1) % NUM_FU;
            end else begin
                exp_valid = 1'b0;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i]) begin
                    model_q[i].push_back(inputEntry(i));
                end
            end
        end
    endtask

    task automatic checkOutput();
        compare("cdb_valid",       32'(cdb_valid),       32'(exp_valid));
        compare("cdb_tag",         32'(cdb_tag),         32'(exp_pkt.tag));
        compare("cdb_value",       cdb_value,            exp_pkt.value);
        compare("cdb_alu_result",  cdb_alu_result,       exp_pkt.alu_result);
        compare("cdb_pc",          cdb_pc,               exp_pkt.pc);
        compare("cdb_npc",         cdb_npc,              exp_pkt.npc);
        compare("cdb_inst",        cdb_inst,             exp_pkt.inst);
        compare("cdb_take_branch", 32'(cdb_take_branch), 32'(exp_pkt.take_branch));
        compare("cdb_grant_fu",    32'(cdb_grant_fu),    32'(exp_grant));
    endtask

    // One cycle: check ready before the edge, clock, then check the CDB.
    task automatic step();
        compare("fu_ready", 32'(fu_ready), 32'(expReady()));
        @(posedge clock);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        logic [NUM_FU-1:0] rand_valid;
        tests_run    = 0;
        tests_failed = 0;

        // Bring the DUT out of its unknown power-up state.
        applyStimulus(1'b1, 1'b0, '0);
        @(posedge clock);
        #1;
        modelReset();

        // Reset state, checked while reset is still high and just after.
        step();
        applyStimulus(1'b0, 1'b0, '0);
        step();

        // Single result from FU1.
        applyStimulus(1'b0, 1'b0, 4'b0010);
        setFu(1, 5'd5, 32'h1234, 32'h100);
        step();
        applyStimulus(1'b0, 1'b0, '0);
        repeat (3) step();

        // Four-way contention, tags 0..3.
        applyStimulus(1'b0, 1'b0, 4'b1111);
        for (int i = 0; i < NUM_FU; i++) begin
            setFu(i, TAG_W'(i), 32'(i) + 32'hA0, 32'(i) * 32'h4);
        end
        step();
        applyStimulus(1'b0, 1'b0, '0);
        repeat (6) step();

        // Fairness: FU0 pushes every cycle, FU2 once.
        applyStimulus(1'b0, 1'b0, 4'b0101);
        step();
        repeat (8) begin
            applyStimulus(1'b0, 1'b0, 4'b0001);
            step();
        end

        // Backpressure: everyone pushes until FIFOs fill.
        repeat (4) begin
            applyStimulus(1'b0, 1'b0, 4'b1111);
            step();
        end

        // Squash with a same-cycle push that must be dropped.
        applyStimulus(1'b0, 1'b1, 4'b0001);
        step();
        applyStimulus(1'b0, 1'b0, '0);
        repeat (3) step();

        // Reset in the middle of a contention burst, then a fresh push.
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 4'b1111);
            step();
        end
        applyStimulus(1'b1, 1'b0, 4'b1111);
        step();
        applyStimulus(1'b0, 1'b0, 4'b0100);
        step();
        applyStimulus(1'b0, 1'b0, '0);
        repeat (3) step();

        // Randomized traffic with rare squash and reset.
        for (int n = 0; n < 400; n++) begin
            rand_valid = NUM_FU'($urandom);
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, rand_valid);
            step();
        end

        // Drain.
        applyStimulus(1'b0, 1'b0, '0);
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
